// File: rtl/bist_pkg.sv
// Shared types and helpers for the multi-session BIST sequencer.
package bist_pkg;

  localparam int DEF_NCLOCK_W = 10;
  localparam int DEF_SIG_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_INIT   = 3'd2,
    ST_RUN    = 3'd3,
    ST_CMP    = 3'd4,
    ST_FINISH = 3'd5
  } bist_state_e;

  // LSB position of session k's golden signature in the flattened bus.
  function automatic int unsigned golden_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/bist_sig_cmp.sv
// Per-session golden select, signature compare and sticky fail mask.
module bist_sig_cmp
  import bist_pkg::*;
#(
  parameter int NSESS  = 2,
  parameter int SIG_W  = DEF_SIG_W,
  parameter int SESS_W = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   cmp_en,
  input  logic [SESS_W-1:0]      sess_idx,
  input  logic [SIG_W-1:0]       sig_in,
  input  logic [NSESS*SIG_W-1:0] golden_sig,
  output logic [NSESS-1:0]       fail_mask
);

  logic [SIG_W-1:0] gold_arr [NSESS];
  logic [NSESS-1:0] mask_q, mask_d;

  for (genvar k = 0; k < NSESS; k++) begin : g_slice
    assign gold_arr[k] = golden_sig[golden_lsb(k, SIG_W) +: SIG_W];
  end

  always_comb begin
    mask_d = mask_q;
    if (cmp_en) mask_d[sess_idx] = (gold_arr[sess_idx] != sig_in);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) mask_q <= '0;
    else                mask_q <= mask_d;
  end

  assign fail_mask = mask_q;

endmodule

// File: rtl/bist_controller_ms.sv
// Multi-session BIST sequencer: NSESS x (init, ncyc running cycles, compare).
// start is a rising-edge request taken only in IDLE; finish is a one-cycle completion pulse.
module bist_controller_ms
  import bist_pkg::*;
#(
  parameter int NCLOCK_W = DEF_NCLOCK_W,
  parameter int NSESS    = 2,
  parameter int SIG_W    = DEF_SIG_W,
  parameter int SESS_W   = (NSESS > 1) ? $clog2(NSESS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NCLOCK_W-1:0]    cfg_ncycles,
  input  logic [SIG_W-1:0]       sig_in,
  input  logic [NSESS*SIG_W-1:0] golden_sig,
  output logic [SESS_W-1:0]      sess_idx,
  output logic                   init,
  output logic                   running,
  output logic                   toggle,
  output logic                   finish,
  output logic                   busy,
  output logic                   bist_end,
  output logic                   pass_fail,
  output logic [NSESS-1:0]       fail_mask,
  output logic                   aborted,
  output bist_state_e            dbg_state
);

  localparam logic [SESS_W-1:0] LAST_SESS = SESS_W'(NSESS - 1);

  bist_state_e         state_q, state_d;
  logic [NCLOCK_W-1:0] cnt_q, cnt_d;
  logic [NCLOCK_W-1:0] ncyc_q, ncyc_d;
  logic [SESS_W-1:0]   sess_q, sess_d;
  logic                start_d_q;
  logic                bist_end_q, bist_end_d;
  logic                aborted_q, aborted_d;
  logic                accept;

  assign accept = (state_q == ST_IDLE) && start && !start_d_q && !abort;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ncyc_d     = ncyc_q;
    sess_d     = sess_q;
    bist_end_d = bist_end_q;
    aborted_d  = aborted_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d    = ST_START;
        ncyc_d     = (cfg_ncycles == '0) ? NCLOCK_W'(1) : cfg_ncycles;
        sess_d     = '0;
        bist_end_d = 1'b0;
        aborted_d  = 1'b0;
      end
      ST_START: state_d = ST_INIT;
      ST_INIT: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ncyc_q - 1'b1) state_d = ST_CMP;
      end
      ST_CMP: begin
        if (sess_q == LAST_SESS) begin
          state_d = ST_FINISH;
        end else begin
          sess_d  = sess_q + 1'b1;
          state_d = ST_INIT;
        end
      end
      ST_FINISH: begin
        state_d    = ST_IDLE;
        bist_end_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort cuts straight to FINISH; the session index stays on the aborted session.
    if (abort && (state_q inside {ST_START, ST_INIT, ST_RUN, ST_CMP})) begin
      state_d   = ST_FINISH;
      sess_d    = sess_q;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ncyc_q     <= NCLOCK_W'(1);
      sess_q     <= '0;
      start_d_q  <= 1'b0;
      bist_end_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ncyc_q     <= ncyc_d;
      sess_q     <= sess_d;
      start_d_q  <= start;
      bist_end_q <= bist_end_d;
      aborted_q  <= aborted_d;
    end
  end

  bist_sig_cmp #(
    .NSESS (NSESS),
    .SIG_W (SIG_W),
    .SESS_W(SESS_W)
  ) u_sig_cmp (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .cmp_en    (state_q == ST_CMP),
    .sess_idx  (sess_q),
    .sig_in    (sig_in),
    .golden_sig(golden_sig),
    .fail_mask (fail_mask)
  );

  assign sess_idx  = sess_q;
  assign init      = (state_q == ST_INIT);
  assign running   = (state_q == ST_RUN);
  assign toggle    = (state_q == ST_RUN) && !cnt_q[0];
  assign finish    = (state_q == ST_FINISH);
  assign busy      = (state_q != ST_IDLE);
  assign bist_end  = bist_end_q;
  assign aborted   = aborted_q;
  assign pass_fail = bist_end_q && !aborted_q && (fail_mask == '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bist_controller_ms.sv
// Randomised bench for bist_controller_ms against a timeline model of each run.
module tb_bist_controller_ms;
  import bist_pkg::*;

  localparam int NCLOCK_W = 10;
  localparam int NSESS    = 2;
  localparam int SIG_W    = 16;
  localparam int SESS_W   = 1;
  localparam int EXP_W    = 8 + SESS_W + NSESS;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset, start, abort;
  logic [NCLOCK_W-1:0]    cfg_ncycles;
  logic [SIG_W-1:0]       sig_in;
  logic [NSESS*SIG_W-1:0] golden_sig;
  logic [SESS_W-1:0]      sess_idx;
  logic                   init, running, toggle, finish, busy, bist_end, pass_fail, aborted;
  logic [NSESS-1:0]       fail_mask;
  bist_state_e            dbg_state;

  bist_controller_ms #(
    .NCLOCK_W(NCLOCK_W), .NSESS(NSESS), .SIG_W(SIG_W), .SESS_W(SESS_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_ncycles(cfg_ncycles), .sig_in(sig_in), .golden_sig(golden_sig),
    .sess_idx(sess_idx), .init(init), .running(running), .toggle(toggle),
    .finish(finish), .busy(busy), .bist_end(bist_end), .pass_fail(pass_fail),
    .fail_mask(fail_mask), .aborted(aborted), .dbg_state(dbg_state)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs in cycle c of a run whose start edge is sampled in cycle 0.
  // A session spans n+2 cycles: init, n running cycles, compare.
  function automatic logic [EXP_W-1:0] exp_word(input int c, input int n, input int a,
                                                input int fin, input bit ab_run,
                                                input logic [NSESS-1:0] mism);
    int len, off, p, cs;
    logic e_init, e_run, e_tog, e_ab, e_be, e_pf;
    logic [SESS_W-1:0] si;
    logic [NSESS-1:0] m;
    len = n + 2;
    e_init = 1'b0; e_run = 1'b0; e_tog = 1'b0; si = '0;
    if (c >= 2 && c < fin) begin
      off    = c - 2;
      p      = off % len;
      si     = SESS_W'(off / len);
      e_init = (p == 0);
      e_run  = (p >= 1 && p <= n);
      e_tog  = e_run && ((p - 1) % 2 == 0);
    end else if (c >= fin) begin
      if (!ab_run)    si = SESS_W'(NSESS - 1);
      else if (a < 2) si = '0;
      else            si = SESS_W'((a - 2) / len);
    end
    m = '0;
    for (int k = 0; k < NSESS; k++) begin
      cs = 3 + k * len + n;
      if (mism[k] && cs < fin && c > cs) m[k] = 1'b1;
    end
    e_ab = ab_run && (c >= fin);
    e_be = (c > fin);
    e_pf = e_be && !e_ab && (m == '0);
    return {(c <= fin), e_init, e_run, e_tog, (c == fin), si, e_be, e_pf, e_ab, m};
  endfunction

  // driver: one full run plus three idle cycles
  task automatic do_run(input int cfg, input logic [NSESS-1:0] mism, input int a,
                        input bit hold, input bit noise);
    int n, fin_n, fin;
    bit ab_run;
    logic [SIG_W-1:0] sigs [NSESS];
    logic [EXP_W-1:0] w;
    logic e_busy, e_init, e_run, e_tog, e_fin, e_be, e_pf, e_ab;
    logic [SESS_W-1:0] e_sess;
    logic [NSESS-1:0] e_mask;
    n      = (cfg == 0) ? 1 : cfg;
    fin_n  = 2 + NSESS * (n + 2);
    ab_run = (a >= 1 && a < fin_n);
    fin    = ab_run ? a + 1 : fin_n;
    for (int k = 0; k < NSESS; k++) begin
      golden_sig[k*SIG_W +: SIG_W] = SIG_W'($urandom);
      sigs[k] = golden_sig[k*SIG_W +: SIG_W] ^
                (mism[k] ? SIG_W'($urandom_range(1, 65535)) : SIG_W'(0));
    end
    for (int c = 1; c <= fin + 3; c++) exp_q.push_back(exp_word(c, n, a, fin, ab_run, mism));
    start = 1'b1; abort = 1'b0;
    cfg_ncycles = NCLOCK_W'(cfg);
    sig_in = SIG_W'($urandom);
    @(negedge clk);
    for (int c = 1; c <= fin + 3; c++) begin
      w = exp_q.pop_front();
      {e_busy, e_init, e_run, e_tog, e_fin, e_sess, e_be, e_pf, e_ab, e_mask} = w;
      check("busy", busy, e_busy);
      check("init", init, e_init);
      check("running", running, e_run);
      check("toggle", toggle, e_tog);
      check("finish", finish, e_fin);
      check("sess_idx", sess_idx, e_sess);
      check("bist_end", bist_end, e_be);
      check("pass_fail", pass_fail, e_pf);
      check("aborted", aborted, e_ab);
      check("fail_mask", fail_mask, e_mask);
      if (hold)                   start = 1'b1;
      else if (noise && c <= fin) start = 1'($urandom_range(0, 1));
      else                        start = 1'b0;
      abort = (c == a) || (noise && !ab_run && c >= fin && $urandom_range(0, 1) == 1);
      cfg_ncycles = NCLOCK_W'($urandom);
      sig_in = sigs[e_sess];
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_init"}, init, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_toggle"}, toggle, 0);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_sess"}, sess_idx, 0);
    check({tag, "_bist_end"}, bist_end, 0);
    check({tag, "_pass_fail"}, pass_fail, 0);
    check({tag, "_fail_mask"}, fail_mask, 0);
    check({tag, "_aborted"}, aborted, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // Reset in session 1 RUN after session 0 has recorded a mismatch.
  task automatic reset_mid_run();
    golden_sig = {SIG_W'($urandom), 16'h1234};
    start = 1'b1; abort = 1'b0; cfg_ncycles = NCLOCK_W'(2);
    sig_in = 16'h1234 ^ 16'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset_running", running, 1);
    check("pre_reset_mask", fail_mask, 2'b01);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_end", bist_end, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_ncycles = '0; sig_in = '0; golden_sig = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    do_run(4, 2'b00, 0, 1'b0, 1'b0);
    do_run(4, 2'b10, 0, 1'b0, 1'b0);
    do_run(4, 2'b00, 4, 1'b0, 1'b0);
    do_run(3, 2'b01, 0, 1'b1, 1'b0);
    do_run(0, 2'b11, 0, 1'b0, 1'b0);

    // start coinciding with abort in IDLE is refused; prior results persist
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("abort_blocks_start", busy, 0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_blocks_start2", busy, 0);
    check("held_end", bist_end, 1);
    check("held_mask", fail_mask, 2'b11);

    do_run(1023, 2'b01, 0, 1'b0, 1'b0);
    do_run(2, 2'b00, 10, 1'b0, 1'b0);
    do_run(2, 2'b01, 5, 1'b0, 1'b0);
    reset_mid_run();

    for (int r = 0; r < 25; r++) begin
      int cfg, a, fin_n;
      cfg   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      fin_n = 2 + NSESS * (((cfg == 0) ? 1 : cfg) + 2);
      a     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, fin_n)) : 0;
      do_run(cfg, NSESS'($urandom_range(0, 3)), a, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bist_controller_ms.md
Name: bist_controller_ms

Overview:
Multi-session BIST sequencer, the parametrised successor to the single-run BIST controller. It runs NSESS back-to-back test sessions. Each session has a seed/init pulse, a programmable number of running cycles and a signature compare against a per-session golden value. It sits between the test-access logic (start/abort/config) and the pattern generator + MISR, and reports aggregate pass/fail plus a per-session fail mask.

Parameters:
NCLOCK_W, 10, width of cycle-count config and internal cycle counter
NSESS, 2, number of sessions per BIST run (1..16)
SIG_W, 16, MISR signature width
SESS_W, $clog2(NSESS) (min 1), width of session index

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  start request, rising-edge sensitive (level held high does not retrigger)
abort  in  1  abort current run
cfg_ncycles  in  NCLOCK_W  running cycles per session, sampled when a start is accepted
sig_in  in  SIG_W  MISR signature, sampled in COMPARE
golden_sig  in  NSESS*SIG_W  golden signatures, session k at bits [k*SIG_W +: SIG_W]
sess_idx  out  SESS_W  current session index (seed select)
init  out  1  seed load / MISR clear pulse
running  out  1  pattern-advance enable
toggle  out  1  alternating stimulus bit
finish  out  1  one-cycle end-of-run pulse
busy  out  1  state != IDLE
bist_end  out  1  sticky done flag (registered)
pass_fail  out  1  1 = pass, valid only while bist_end=1, else 0
fail_mask  out  NSESS  bit k set = session k signature mismatch
aborted  out  1  sticky: last run ended by abort

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, sess_idx=0, counter=0, start_d=0, bist_end=0, fail_mask=0, aborted=0. All pulse outputs 0. Reset dominates every other input.
- start_rise = start & ~start_d; start_d is a registered copy of start, cleared by reset.
- States: IDLE, START, INIT, RUN, COMPARE, FINISH.
- IDLE: on start_rise & ~abort -> START. On acceptance: latch ncyc_r = (cfg_ncycles==0) ? 1 : cfg_ncycles; clear bist_end, fail_mask and aborted; sess_idx=0. abort in IDLE is ignored, and it blocks a simultaneous start.
- START -> INIT. One cycle, no outputs other than busy.
- INIT: init=1 for one cycle -> RUN; counter=0.
- RUN: running=1. The counter increments each cycle. toggle = ~counter[0], so the pattern is 1,0,1,0… starting on the first RUN cycle. When counter == ncyc_r-1 -> COMPARE. RUN lasts exactly ncyc_r cycles.
- COMPARE: one cycle. fail_mask[sess_idx] <= (sig_in != golden_sig[sess_idx]).
  - If sess_idx < NSESS-1: sess_idx++ and go to INIT.
  - Otherwise go to FINISH.
- FINISH: finish=1 for one cycle -> IDLE. The cycle after FINISH: bist_end=1 and pass_fail = ~aborted & (fail_mask==0), taking into account the last compare, which completes before FINISH.
- abort in START/INIT/RUN/COMPARE: the next state is FINISH and aborted<=1. A COMPARE coinciding with abort still records its fail bit. abort during FINISH has no effect.
- bist_end, pass_fail, fail_mask and aborted hold until the next accepted start or reset. Outputs are combinational decodes of state/counter except where noted as registered.
- Run length, with the start edge sampled in cycle 0: FINISH in cycle 1 + NSESS*(ncyc_r+2) + 1; bist_end rises one cycle later.
- A start edge while busy is ignored and not queued. cfg_ncycles changes mid-run have no effect.
- Counter width is NCLOCK_W, so cfg = 2^NCLOCK_W-1 must terminate without wrap.

Decomposition:
- Package bist_pkg: state enum (6 states, 3 bits), default widths NCLOCK_W/SIG_W, helper function for golden slice select.
- Sub-module bist_sig_cmp: golden slice mux + compare + fail_mask register. It is registered and cleared on reset or accepted start.
- Edge detect and FSM stay in the top module.

Test Plan:
- NSESS=2, cfg=4, sigs match golden: init at c2 and c8; running c3–6 and c9–12; toggle 1,0,1,0 each session; FINISH c14; bist_end=1 from c15 with pass_fail=1, fail_mask=2'b00.
- Same setup, session 1 sig_in differs from golden: fail_mask=2'b10, pass_fail=0, bist_end=1 at c15.
- abort asserted in the 2nd RUN cycle of session 0: FINISH the next cycle, aborted=1, bist_end=1 the cycle after, pass_fail=0, session 1 never runs.
- start held high across run completion: no second run. Deassert then reassert: new run starts, bist_end drops to 0 the cycle after acceptance.
- cfg_ncycles=0: each RUN lasts exactly 1 cycle (toggle=1). cfg=1023 with NCLOCK_W=10: RUN lasts 1023 cycles, no wrap.
- reset asserted mid-RUN: next cycle state IDLE, all outputs 0, fail_mask=0. start pulsed the same cycle as reset is ignored.
